// File: rtl/vga_pkg.sv
// Shared types and helpers for the camera-to-VGA line capture buffer.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LINE,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  localparam int VGA_H_BYTES = 1280;
  localparam int VGA_V_LINES = 480;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/vga_byte_packer.sv
// Packs camera bytes MSB-first into BYTES_PER_WORD-byte words; the byte
// counter restarts on every first byte of a line, so partial words are dropped.
module vga_byte_packer
  import vga_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2
) (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  input  logic                        i_cap,
  input  logic                        i_sol,
  input  logic [7:0]                  i_byte,
  output logic [8*BYTES_PER_WORD-1:0] o_word,
  output logic                        o_word_vld
);

  localparam int CW = (clog2(BYTES_PER_WORD) < 1) ? 1 : clog2(BYTES_PER_WORD);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_eff;

  // The line-start byte is always byte 0 of a fresh word.
  assign w_cnt_eff  = i_sol ? '0 : r_cnt;
  assign o_word_vld = i_cap && (w_cnt_eff == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_cap) r_cnt <= o_word_vld ? '0 : w_cnt_eff + CW'(1);
    else if (i_sol) r_cnt <= '0;
  end

  generate
    if (BYTES_PER_WORD == 1) begin : g_single
      assign o_word = i_byte;
    end else begin : g_shift
      logic [8*(BYTES_PER_WORD-1)-1:0] r_sr;
      assign o_word = {r_sr, i_byte};
      always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)     r_sr <= '0;
        else if (i_cap) r_sr <= o_word[8*(BYTES_PER_WORD-1)-1:0];
      end
    end
  endgenerate

endmodule

// File: rtl/vga_line_buf.sv
// Captures a NUM_LINES window of camera lines into the VGA line RAM.
// Define VGA_LINE_BUF_PINGPONG_EN to alternate windows between two RAM banks.
module vga_line_buf
  import vga_pkg::*;
#(
  parameter int BYTES_PER_WORD = 2,
  parameter int WORDS_PER_LINE = VGA_H_BYTES / 2,
  parameter int NUM_LINES      = 4,
  parameter int ADDR_W         = 12
) (
  input  logic                        clk_sys,
  input  logic                        rst_n,
  input  logic [15:0]                 num_line,
  input  logic [15:0]                 num_pclk,
  input  logic [7:0]                  data_pclk,
  input  logic                        data_vld,
  input  logic                        cap_en,
  input  logic [15:0]                 line_start,
  output logic [8*BYTES_PER_WORD-1:0] ram_wdata,
  output logic [ADDR_W-1:0]           ram_waddr,
  output logic                        ram_wren,
  output logic                        cap_busy,
  output logic                        cap_done,
  output logic                        cap_bank
);

  cap_state_e r_state, w_state_nxt;

  logic [15:0]                 r_ls, r_end, r_widx;
  logic [16:0]                 w_end_sum;
  logic [15:0]                 w_end_sat, w_idx_eff;
  logic                        w_sol, w_in_win, w_cap, w_arm, w_idx_ok;
  logic [8*BYTES_PER_WORD-1:0] w_word;
  logic                        w_word_vld;
  logic [ADDR_W-1:0]           w_base, w_waddr;

  assign w_sol     = data_vld && (num_pclk == 16'd0);
  assign w_in_win  = (num_line >= r_ls) && (num_line <= r_end);
  assign w_end_sum = {1'b0, line_start} + 17'(NUM_LINES - 1);
  assign w_end_sat = w_end_sum[16] ? 16'hFFFF : w_end_sum[15:0];

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_arm       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cap_en) begin
          w_state_nxt = ST_WAIT_LINE;
          w_arm       = 1'b1;
        end
      end
      ST_WAIT_LINE: begin
        if (!cap_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sol && (num_line == r_ls)) begin
          w_state_nxt = ST_CAPTURE;
          w_cap       = 1'b1;
        end
      end
      ST_CAPTURE: begin
        // Leaving the window either way (past the end or frame wrap) closes it.
        if (data_vld) begin
          if (w_in_win) w_cap = 1'b1;
          else          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = cap_en ? ST_WAIT_LINE : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ls    <= '0;
      r_end   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_arm) begin
        r_ls  <= line_start;
        r_end <= w_end_sat;
      end
    end
  end

  assign cap_busy = (r_state == ST_WAIT_LINE) || (r_state == ST_CAPTURE);
  assign cap_done = (r_state == ST_DONE);

  vga_byte_packer #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_packer (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .i_cap     (w_cap),
    .i_sol     (w_sol),
    .i_byte    (data_pclk),
    .o_word    (w_word),
    .o_word_vld(w_word_vld)
  );

  // Word index saturates at WORDS_PER_LINE so overlong lines stay suppressed.
  assign w_idx_eff = w_sol ? 16'd0 : r_widx;
  assign w_idx_ok  = 32'(w_idx_eff) < WORDS_PER_LINE;
  assign w_base    = ADDR_W'(32'(num_line - r_ls) * WORDS_PER_LINE + 32'(w_idx_eff));

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                        r_widx <= '0;
    else if (w_sol)                    r_widx <= w_word_vld ? 16'd1 : 16'd0;
    else if (w_word_vld && w_idx_ok)   r_widx <= r_widx + 16'd1;
  end

`ifdef VGA_LINE_BUF_PINGPONG_EN
  logic r_wr_bank, r_cap_bank, w_close;

  assign w_close  = (r_state == ST_CAPTURE) && data_vld && !w_in_win;
  assign w_waddr  = {r_wr_bank, w_base[ADDR_W-2:0]};
  assign cap_bank = r_cap_bank;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_cap_bank <= 1'b0;
    end else if (w_close) begin
      r_cap_bank <= r_wr_bank;
      r_wr_bank  <= ~r_wr_bank;
    end
  end
`else
  assign w_waddr  = w_base;
  assign cap_bank = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ram_wren  <= 1'b0;
      ram_wdata <= '0;
      ram_waddr <= '0;
    end else begin
      ram_wren <= w_word_vld && w_idx_ok;
      if (w_word_vld && w_idx_ok) begin
        ram_wdata <= w_word;
        ram_waddr <= w_waddr;
      end
    end
  end

endmodule

// File: tb/tb_vga_line_buf.sv
// Scoreboarded bench for vga_line_buf: a 2-byte/640-word instance and a
// 4-byte/4-word instance share the camera stream.
module tb_vga_line_buf;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] num_line = '0, num_pclk = '0, line_start = '0;
  logic [7:0]  data_pclk = '0;
  logic        data_vld = 1'b0, cap_en_a = 1'b0, cap_en_b = 1'b0;

  logic [15:0] ram_wdata_a;
  logic [11:0] ram_waddr_a;
  logic        ram_wren_a, cap_busy_a, cap_done_a, cap_bank_a;
  logic [31:0] ram_wdata_b;
  logic [3:0]  ram_waddr_b;
  logic        ram_wren_b, cap_busy_b, cap_done_b, cap_bank_b;

  int n_checks = 0, n_pass = 0;
  int n_done_a = 0, n_done_b = 0, n_wr_a = 0, n_wr_b = 0;
  logic last_bank_a = 1'b0, last_bank_b = 1'b0;
  int wbank_a = 0;
  logic [27:0] q_a[$];
  logic [35:0] q_b[$];
  logic [27:0] e_a;
  logic [35:0] e_b;

  always #5 clk_sys = ~clk_sys;

  vga_line_buf #(.BYTES_PER_WORD(2), .WORDS_PER_LINE(640), .NUM_LINES(3), .ADDR_W(12)) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .num_line(num_line), .num_pclk(num_pclk),
    .data_pclk(data_pclk), .data_vld(data_vld), .cap_en(cap_en_a), .line_start(line_start),
    .ram_wdata(ram_wdata_a), .ram_waddr(ram_waddr_a), .ram_wren(ram_wren_a),
    .cap_busy(cap_busy_a), .cap_done(cap_done_a), .cap_bank(cap_bank_a));

  vga_line_buf #(.BYTES_PER_WORD(4), .WORDS_PER_LINE(4), .NUM_LINES(2), .ADDR_W(4)) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .num_line(num_line), .num_pclk(num_pclk),
    .data_pclk(data_pclk), .data_vld(data_vld), .cap_en(cap_en_b), .line_start(line_start),
    .ram_wdata(ram_wdata_b), .ram_waddr(ram_waddr_b), .ram_wren(ram_wren_b),
    .cap_busy(cap_busy_b), .cap_done(cap_done_b), .cap_bank(cap_bank_b));

  always @(negedge clk_sys) begin
    if (ram_wren_a) begin
      n_wr_a++; n_checks++;
      if (q_a.size() == 0)
        $display("FAIL wr_a_unexpected: got addr=%0d data=%h, required no write", ram_waddr_a, ram_wdata_a);
      else begin
        e_a = q_a.pop_front();
        if ({ram_waddr_a, ram_wdata_a} !== e_a)
          $display("FAIL wr_a: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_waddr_a, ram_wdata_a, e_a[27:16], e_a[15:0]);
        else n_pass++;
      end
    end
    if (ram_wren_b) begin
      n_wr_b++; n_checks++;
      if (q_b.size() == 0)
        $display("FAIL wr_b_unexpected: got addr=%0d data=%h, required no write", ram_waddr_b, ram_wdata_b);
      else begin
        e_b = q_b.pop_front();
        if ({ram_waddr_b, ram_wdata_b} !== e_b)
          $display("FAIL wr_b: got addr=%0d data=%h, required addr=%0d data=%h",
                   ram_waddr_b, ram_wdata_b, e_b[35:32], e_b[31:0]);
        else n_pass++;
      end
    end
    if (cap_done_a) begin n_done_a++; last_bank_a = cap_bank_a; end
    if (cap_done_b) begin n_done_b++; last_bank_b = cap_bank_b; end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic drive_byte(input logic [15:0] ln, input logic [15:0] pc);
    num_line = ln; num_pclk = pc; data_pclk = pc[7:0]; data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
  endtask

  task automatic stream_line(input logic [15:0] ln, input int nb);
    for (int p = 0; p < nb; p++) drive_byte(ln, 16'(p));
  endtask

  // Bytes equal num_pclk[7:0], so word w of a line is {2w, 2w+1}.
  task automatic expect_line_a(input int rel, input int nbytes);
    for (int w = 0; w < nbytes / 2 && w < 640; w++)
      q_a.push_back({12'(wbank_a * 2048 + rel * 640 + w), 8'(2 * w), 8'(2 * w + 1)});
  endtask

  task automatic window_done_a();
`ifdef VGA_LINE_BUF_PINGPONG_EN
    wbank_a = 1 - wbank_a;
`endif
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_sys);
    n_checks++; if (ram_wren_a !== 1'b0) $display("FAIL rst_wren: got %b required 0", ram_wren_a); else n_pass++;
    n_checks++; if (ram_waddr_a !== 12'd0) $display("FAIL rst_waddr: got %0d required 0", ram_waddr_a); else n_pass++;
    n_checks++; if (ram_wdata_a !== 16'd0) $display("FAIL rst_wdata: got %h required 0", ram_wdata_a); else n_pass++;
    n_checks++; if ({cap_busy_a, cap_done_a, cap_bank_a} !== 3'b000)
      $display("FAIL rst_status: got %b required 000", {cap_busy_a, cap_done_a, cap_bank_a}); else n_pass++;
    n_checks++; if ({ram_wren_b, cap_busy_b, cap_done_b} !== 3'b000)
      $display("FAIL rst_b: got %b required 000", {ram_wren_b, cap_busy_b, cap_done_b}); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    int d0;
    line_start = 16'd100; cap_en_a = 1'b1;
    tick();
    n_checks++; if (cap_busy_a !== 1'b1) $display("FAIL b2b_armed: got %b required 1", cap_busy_a); else n_pass++;
    for (int win = 0; win < 2; win++) begin
      for (int l = 0; l < 3; l++) expect_line_a(l, 4);
      stream_line(16'd99, 4);
      for (int l = 0; l < 3; l++) stream_line(16'(100 + l), 4);
      d0 = n_done_a;
      // Second window closes on a frame wrap instead of the line after the window.
      stream_line((win == 0) ? 16'd103 : 16'd0, 2);
      tick();
      n_checks++; if (n_done_a !== d0 + 1) $display("FAIL b2b_done%0d: got %0d pulses required 1", win, n_done_a - d0); else n_pass++;
      n_checks++; if (last_bank_a !== wbank_a[0]) $display("FAIL b2b_bank%0d: got %b required %b", win, last_bank_a, wbank_a[0]); else n_pass++;
      n_checks++; if (q_a.size() != 0) $display("FAIL b2b_drain%0d: got %0d pending required 0", win, q_a.size()); else n_pass++;
      window_done_a();
    end
    n_checks++; if (cap_busy_a !== 1'b1) $display("FAIL b2b_rearm: got %b required 1", cap_busy_a); else n_pass++;
    cap_en_a = 1'b0;
    tick(); tick();
    n_checks++; if (cap_busy_a !== 1'b0) $display("FAIL b2b_idle: got %b required 0", cap_busy_a); else n_pass++;
  endtask

  task automatic test_single_window();
    int d0, w0;
    line_start = 16'd240; cap_en_a = 1'b1;
    tick();
    for (int l = 0; l < 3; l++) expect_line_a(l, 1280);
    w0 = n_wr_a;
    stream_line(16'd239, 8);
    for (int l = 0; l < 3; l++) stream_line(16'(240 + l), 1280);
    d0 = n_done_a;
    stream_line(16'd243, 2);
    tick();
    n_checks++; if (n_done_a !== d0 + 1) $display("FAIL sw_done: got %0d pulses required 1", n_done_a - d0); else n_pass++;
    n_checks++; if (n_wr_a - w0 != 1920) $display("FAIL sw_count: got %0d writes required 1920", n_wr_a - w0); else n_pass++;
    n_checks++; if (q_a.size() != 0) $display("FAIL sw_drain: got %0d pending required 0", q_a.size()); else n_pass++;
    window_done_a();
    cap_en_a = 1'b0;
    tick(); tick();
    n_checks++; if (cap_busy_a !== 1'b0) $display("FAIL sw_idle: got %b required 0", cap_busy_a); else n_pass++;
  endtask

  task automatic test_gaps_cap_drop();
    int d0;
    line_start = 16'd50; cap_en_a = 1'b1;
    tick();
    expect_line_a(0, 8);
    drive_byte(16'd50, 16'd0);
    cap_en_a = 1'b0;
    n_checks++; if (ram_wren_a !== 1'b0) $display("FAIL gap_byte0: got wren %b required 0", ram_wren_a); else n_pass++;
    repeat (3) tick();
    n_checks++; if (ram_wren_a !== 1'b0) $display("FAIL gap_idle: got wren %b required 0", ram_wren_a); else n_pass++;
    drive_byte(16'd50, 16'd1);
    n_checks++; if (ram_wren_a !== 1'b1 || ram_wdata_a !== 16'h0001)
      $display("FAIL gap_word0: got wren %b data %h required 1 0001", ram_wren_a, ram_wdata_a); else n_pass++;
    for (int p = 2; p < 8; p++) drive_byte(16'd50, 16'(p));
    for (int l = 1; l < 3; l++) begin
      expect_line_a(l, 8);
      stream_line(16'(50 + l), 8);
    end
    d0 = n_done_a;
    stream_line(16'd53, 2);
    tick();
    n_checks++; if (n_done_a !== d0 + 1) $display("FAIL drop_done: got %0d pulses required 1", n_done_a - d0); else n_pass++;
    n_checks++; if (cap_busy_a !== 1'b0) $display("FAIL drop_idle: got %b required 0", cap_busy_a); else n_pass++;
    n_checks++; if (q_a.size() != 0) $display("FAIL drop_drain: got %0d pending required 0", q_a.size()); else n_pass++;
    window_done_a();
  endtask

  task automatic test_multi_line();
    int d0;
    line_start = 16'd10; cap_en_a = 1'b1;
    tick();
    for (int l = 0; l < 3; l++) expect_line_a(l, 8);
    stream_line(16'd10, 8);
    stream_line(16'd11, 8);
    stream_line(16'd12, 4);
    n_checks++; if (ram_waddr_a !== 12'(wbank_a * 2048 + 1281) || ram_wdata_a !== 16'h0203)
      $display("FAIL ml_l12w1: got addr %0d data %h required %0d 0203", ram_waddr_a, ram_wdata_a, wbank_a * 2048 + 1281);
    else n_pass++;
    for (int p = 4; p < 8; p++) drive_byte(16'd12, 16'(p));
    cap_en_a = 1'b0;
    d0 = n_done_a;
    stream_line(16'd13, 2);
    tick();
    n_checks++; if (n_done_a !== d0 + 1) $display("FAIL ml_done: got %0d pulses required 1", n_done_a - d0); else n_pass++;
    n_checks++; if (q_a.size() != 0) $display("FAIL ml_drain: got %0d pending required 0", q_a.size()); else n_pass++;
    window_done_a();
  endtask

  task automatic test_reset_mid();
    int d0;
    line_start = 16'd20; cap_en_a = 1'b1;
    tick();
    expect_line_a(0, 6);
    stream_line(16'd20, 6);
    @(negedge clk_sys); #1;
    n_checks++; if (q_a.size() != 0) $display("FAIL rm_pre: got %0d pending required 0", q_a.size()); else n_pass++;
    d0 = n_done_a;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({ram_wren_a, ram_waddr_a, ram_wdata_a, cap_busy_a, cap_done_a, cap_bank_a} !== 31'd0)
      $display("FAIL rm_async: got wren %b addr %0d data %h busy %b required all 0",
               ram_wren_a, ram_waddr_a, ram_wdata_a, cap_busy_a); else n_pass++;
    @(negedge clk_sys);
    rst_n = 1'b1;
    wbank_a = 0;
    tick();
    for (int p = 6; p < 10; p++) drive_byte(16'd20, 16'(p));
    stream_line(16'd21, 4);
    n_checks++; if (n_done_a !== d0) $display("FAIL rm_nodone: got %0d pulses required 0", n_done_a - d0); else n_pass++;
    n_checks++; if (cap_busy_a !== 1'b1) $display("FAIL rm_rearm: got %b required 1", cap_busy_a); else n_pass++;
    for (int l = 0; l < 3; l++) begin
      expect_line_a(l, 4);
      stream_line(16'(20 + l), 4);
    end
    cap_en_a = 1'b0;
    stream_line(16'd23, 2);
    tick();
    n_checks++; if (n_done_a !== d0 + 1) $display("FAIL rm_done: got %0d pulses required 1", n_done_a - d0); else n_pass++;
    n_checks++; if (q_a.size() != 0) $display("FAIL rm_drain: got %0d pending required 0", q_a.size()); else n_pass++;
    window_done_a();
  endtask

  task automatic test_trunc_partial();
    line_start = 16'd5; cap_en_b = 1'b1;
    tick();
    q_b.push_back({4'd0, 32'h00010203});
    q_b.push_back({4'd1, 32'h04050607});
    for (int w = 0; w < 4; w++)
      q_b.push_back({4'(4 + w), 8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)});
    stream_line(16'd5, 11);
    stream_line(16'd6, 24);
    cap_en_b = 1'b0;
    stream_line(16'd7, 2);
    tick();
    n_checks++; if (n_wr_b != 6) $display("FAIL tr_count: got %0d writes required 6", n_wr_b); else n_pass++;
    n_checks++; if (n_done_b != 1) $display("FAIL tr_done: got %0d pulses required 1", n_done_b); else n_pass++;
    n_checks++; if (last_bank_b !== 1'b0) $display("FAIL tr_bank: got %b required 0", last_bank_b); else n_pass++;
    n_checks++; if (q_b.size() != 0) $display("FAIL tr_drain: got %0d pending required 0", q_b.size()); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_single_window();
    test_gaps_cap_drop();
    test_multi_line();
    test_reset_mid();
    test_trunc_partial();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_line_buf.md
Name: vga_line_buf

Overview:
- Parametrised capture buffer between the OV camera pixel interface and the HMI VGA line RAM.
- Captures a programmable window of NUM_LINES consecutive camera lines, starting at line_start.
- Packs BYTES_PER_WORD camera bytes into each RAM word and writes the words to consecutive RAM addresses.
- Emits a one-cycle done pulse per captured window so the VGA reader can consume it; optionally alternates between two RAM banks.

Parameters:
- BYTES_PER_WORD, 2, bytes packed per RAM word; power of two, 1..4; first byte lands in the MSBs.
- WORDS_PER_LINE, 640, maximum words stored per line; words beyond this are dropped.
- NUM_LINES, 4, lines captured per window.
- ADDR_W, 12, RAM address width; must satisfy NUM_LINES*WORDS_PER_LINE <= 2^ADDR_W, and <= 2^(ADDR_W-1) when VGA_LINE_BUF_PINGPONG_EN is defined.

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- num_line  in  16  current camera line index.
- num_pclk  in  16  byte index within the line; 0 marks the first byte.
- data_pclk  in  8  camera byte.
- data_vld  in  1  data_pclk valid this cycle.
- cap_en  in  1  level; arms and continues capture.
- line_start  in  16  first line of the window; sampled on arm.
- ram_wdata  out  8*BYTES_PER_WORD  packed word.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wren  out  1  write strobe.
- cap_busy  out  1  high in WAIT_LINE and CAPTURE.
- cap_done  out  1  one-cycle pulse at window completion.
- cap_bank  out  1  bank holding the last completed window; constant 0 without ping-pong.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, byte counter 0, shift register 0. Reset is asynchronous and clears state mid-window; the partially written window is abandoned and cap_done does not fire.
- FSM states:
  - IDLE: when cap_en=1, latch line_start into ls_q, compute end_q = ls_q + NUM_LINES - 1 (17-bit, saturate at 0xFFFF), go to WAIT_LINE.
  - WAIT_LINE: go to CAPTURE on the cycle with data_vld=1, num_line==ls_q, num_pclk==0. That byte is captured.
  - CAPTURE: accept bytes while ls_q <= num_line <= end_q. On the first data_vld with num_line > end_q, or with num_line < ls_q (frame wrap), go to DONE; that byte is not captured.
  - DONE: one cycle. cap_done=1, cap_bank updated. Go to WAIT_LINE if cap_en=1, else IDLE.
- cap_en dropped during WAIT_LINE returns the FSM to IDLE. cap_en dropped during CAPTURE has no effect; the window completes.
- Packing:
  - A byte counter of width log2(BYTES_PER_WORD) is forced to 0 on data_vld with num_pclk==0, then increments on each captured byte.
  - Bytes shift in MSB-first.
  - When the counter reaches BYTES_PER_WORD-1, the full word is registered and written.
  - A partial word left at end of line is discarded at the next num_pclk==0.
- Address: ram_waddr = bank*2^(ADDR_W-1) + (num_line-ls_q)*WORDS_PER_LINE + word_idx. word_idx resets per line. Words with word_idx >= WORDS_PER_LINE are suppressed (no wren).
- Latency: ram_wren, ram_wdata and ram_waddr are registered, asserted 1 cycle after the completing byte's data_vld. wren is a single cycle per word.
- data_vld=0 cycles freeze all packing state. Gaps within a line are legal.

Optional Feature:
- Macro VGA_LINE_BUF_PINGPONG_EN.
- Defined: the write bank toggles at every DONE, and the address MSB selects the bank. cap_bank = the bank just completed, so the reader uses cap_bank while the writer fills the opposite bank.
- Undefined: single bank, address MSB treated as ordinary address, cap_bank tied 0.

Decomposition:
- Package vga_pkg:
  - FSM state encoding (IDLE, WAIT_LINE, CAPTURE, DONE).
  - Default geometry constants: VGA_H_BYTES=1280, VGA_V_LINES=480.
  - Function clog2.
- One sub-module, vga_byte_packer: byte counter, shift register and word-complete strobe, parametrised by BYTES_PER_WORD.
- The FSM and address generation stay in vga_line_buf.

Test Plan:
- Single window: BPW=2, NUM_LINES=1, line_start=240; stream lines 239..241 of 1280 bytes, bytes=num_pclk[7:0] -> exactly 640 wrens at addr 0..639, word0=16'h0001, word1=16'h0203; cap_done pulses once after line 241 begins.
- Multi-line: NUM_LINES=4, line_start=10, 8 bytes per line -> 16 writes. Line 12 word 1 lands at addr 2*640+1=1281.
- Truncation and partial word: WORDS_PER_LINE=4, line of 11 bytes, BPW=4 -> 2 wrens per line (8 bytes); the trailing 3 bytes never write.
- Ping-pong (macro on): two windows back-to-back with cap_en held -> first window addrs 0.., cap_bank=0; second window addrs 2048.., cap_bank=1.
- Mid-operation events:
  - cap_en dropped in CAPTURE -> window completes, FSM goes to IDLE.
  - rst_n low mid-line -> all outputs 0 asynchronously, no cap_done.
  - After release with cap_en=1, capture restarts only at the next num_pclk==0 of line_start.
- data_vld gaps: insert idle cycles between bytes 0 and 1 -> word still 16'h0001, wren one cycle after byte 1.
